// File: rtl/demux_rr_n.sv
// 1-to-NCH registered demultiplexer with one output slot per channel.
// Routes by sel_in (MODE=0) or by an internal round-robin pointer (MODE=1).
module demux_rr_n #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [SELW-1:0]        sel_in,
  output logic [NCH*WIDTH-1:0]   data_out,
  output logic [NCH-1:0]         valid_out,
  input  logic [NCH-1:0]         ready_out,
  output logic [SELW-1:0]        rr_ptr,
  output logic                   sel_err
);

  // Handshake: a word moves on any rising edge where valid and ready are both 1;
  // valid never waits on ready, and ready_in may depend combinationally on ready_out.

  localparam logic [SELW:0]   NCH_W    = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] PTR_LAST = SELW'(NCH - 1);

  logic [SELW-1:0]     target;
  logic                in_range;
  logic [2**SELW-1:0]  free_pad;
  logic                accept;
  logic [NCH-1:0]      load;

  always_comb begin
    target   = (MODE == 1) ? rr_ptr : sel_in;
    in_range = ({1'b0, target} < NCH_W);
    // Out-of-range selects land on padding that is always free, so they are consumed.
    free_pad = '1;
    free_pad[NCH-1:0] = ~valid_out | ready_out;
    ready_in = !reset && (!in_range || free_pad[target]);
    accept   = valid_in && ready_in;
    load     = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept && in_range && (target == SELW'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= '0;
      rr_ptr    <= '0;
      sel_err   <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          data_out[k*WIDTH +: WIDTH] <= data_in;
          valid_out[k]               <= 1'b1;
        end else if (ready_out[k]) begin
          valid_out[k] <= 1'b0;
        end
      end
      if (accept && !in_range) begin
        sel_err <= 1'b1;
      end
      // The pointer is the round-robin FSM state: it only moves on an accepted word.
      if (MODE == 1 && accept) begin
        rr_ptr <= (rr_ptr == PTR_LAST) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_rr_n.sv
// Bench for demux_rr_n: three instances (sel routing NCH=4, round-robin NCH=4,
// sel routing NCH=3) checked every cycle against a slot-level model plus directed cases.
module tb_demux_rr_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus; index 0: MODE0/NCH4, 1: MODE1/NCH4, 2: MODE0/NCH3
  logic       rst  [3];
  logic [7:0] din  [3];
  logic       vin  [3];
  logic [1:0] sel  [3];
  logic [3:0] rout [3];

  logic       rin  [3];
  logic [1:0] ptr  [3];
  logic       err  [3];
  logic [31:0] dout0, dout1;
  logic [23:0] dout2;
  logic [3:0]  vout0, vout1;
  logic [2:0]  vout2;

  int nch  [3] = '{4, 4, 3};
  int mode [3] = '{0, 1, 0};

  demux_rr_n #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(0)) u_dut0 (
    .clk(clk), .reset(rst[0]), .data_in(din[0]), .valid_in(vin[0]), .ready_in(rin[0]),
    .sel_in(sel[0]), .data_out(dout0), .valid_out(vout0), .ready_out(rout[0]),
    .rr_ptr(ptr[0]), .sel_err(err[0]));

  demux_rr_n #(.WIDTH(8), .NCH(4), .SELW(2), .MODE(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .data_in(din[1]), .valid_in(vin[1]), .ready_in(rin[1]),
    .sel_in(sel[1]), .data_out(dout1), .valid_out(vout1), .ready_out(rout[1]),
    .rr_ptr(ptr[1]), .sel_err(err[1]));

  demux_rr_n #(.WIDTH(8), .NCH(3), .SELW(2), .MODE(0)) u_dut2 (
    .clk(clk), .reset(rst[2]), .data_in(din[2]), .valid_in(vin[2]), .ready_in(rin[2]),
    .sel_in(sel[2]), .data_out(dout2), .valid_out(vout2), .ready_out(rout[2][2:0]),
    .rr_ptr(ptr[2]), .sel_err(err[2]));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_valid [3][4];
  logic [7:0] m_data  [3][4];
  int         m_ptr   [3];
  bit         m_err   [3];
  bit         started = 0;

  function automatic int m_target(int d);
    return (mode[d] == 1) ? m_ptr[d] : int'(sel[d]);
  endfunction

  function automatic bit m_ready(int d);
    int t;
    t = m_target(d);
    if (rst[d]) return 1'b0;
    if (t >= nch[d]) return 1'b1;
    return !m_valid[d][t] || rout[d][t];
  endfunction

  function automatic logic [3:0] get_vout(int d);
    return (d == 0) ? vout0 : (d == 1) ? vout1 : {1'b0, vout2};
  endfunction

  function automatic logic [31:0] get_dout(int d);
    return (d == 0) ? dout0 : (d == 1) ? dout1 : {8'h00, dout2};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        for (int c = 0; c < 4; c++) begin
          m_valid[d][c] = 1'b0;
          m_data[d][c]  = 8'h00;
        end
        m_ptr[d] = 0;
        m_err[d] = 1'b0;
      end else begin
        bit acc;
        int t;
        acc = vin[d] && m_ready(d);
        t   = m_target(d);
        for (int c = 0; c < nch[d]; c++) begin
          if (acc && t == c) begin
            m_valid[d][c] = 1'b1;
            m_data[d][c]  = din[d];
          end else if (rout[d][c]) begin
            m_valid[d][c] = 1'b0;
          end
        end
        if (acc && t >= nch[d]) m_err[d] = 1'b1;
        if (acc && mode[d] == 1) m_ptr[d] = (m_ptr[d] + 1) % nch[d];
      end
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 3; d++) begin
        logic [3:0]  ev;
        logic [31:0] ed;
        ev = '0;
        ed = '0;
        for (int c = 0; c < nch[d]; c++) begin
          ev[c]        = m_valid[d][c];
          ed[c*8 +: 8] = m_data[d][c];
        end
        chk($sformatf("d%0d ready_in", d), {31'd0, rin[d]}, {31'd0, m_ready(d)});
        chk($sformatf("d%0d valid_out", d), {28'd0, get_vout(d)}, {28'd0, ev});
        chk($sformatf("d%0d data_out", d), get_dout(d), ed);
        chk($sformatf("d%0d rr_ptr", d), {30'd0, ptr[d]}, 32'(m_ptr[d]));
        chk($sformatf("d%0d sel_err", d), {31'd0, err[d]}, {31'd0, m_err[d]});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; din[d] = 8'h00; vin[d] = 1'b1; sel[d] = 2'd0; rout[d] = 4'h0;
    end

    // Reset holds everything idle even with valid_in high
    repeat (2) begin
      tick();
      #1;
      chk("reset ready_in", {31'd0, rin[0]}, 32'd0);
      chk("reset valid_out", {28'd0, vout0}, 32'd0);
      chk("reset data_out", dout0, 32'd0);
      chk("reset sel_err", {31'd0, err[0]}, 32'd0);
    end
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; vin[d] = 1'b0;
    end
    tick();

    // Routing by select
    rout[0] = 4'hf; vin[0] = 1'b1; din[0] = 8'hA1; sel[0] = 2'd2;
    #1 chk("route ready_in", {31'd0, rin[0]}, 32'd1);
    tick();
    din[0] = 8'hB2; sel[0] = 2'd0;
    #1 chk("route vout A1", {28'd0, vout0}, 32'h4);
    chk("route data ch2", {24'd0, dout0[23:16]}, 32'hA1);
    tick();
    vin[0] = 1'b0;
    #1 chk("route vout B2", {28'd0, vout0}, 32'h1);
    chk("route data ch0", {24'd0, dout0[7:0]}, 32'hB2);

    // Backpressure on lane 1
    rout[0] = 4'b1101; vin[0] = 1'b1; din[0] = 8'h11; sel[0] = 2'd1;
    #1 chk("bp first ready", {31'd0, rin[0]}, 32'd1);
    tick();
    din[0] = 8'h22;
    #1 chk("bp blocked ready", {31'd0, rin[0]}, 32'd0);
    chk("bp data 11", {24'd0, dout0[15:8]}, 32'h11);
    chk("bp vout", {28'd0, vout0}, 32'h2);
    tick();
    #1 chk("bp still blocked", {31'd0, rin[0]}, 32'd0);
    rout[0] = 4'hf;
    #1 chk("bp released ready", {31'd0, rin[0]}, 32'd1);
    tick();
    vin[0] = 1'b0;
    #1 chk("bp data 22", {24'd0, dout0[15:8]}, 32'h22);
    chk("bp lane1 valid", {31'd0, vout0[1]}, 32'd1);
    tick();

    // Round robin with an idle gap
    rout[1] = 4'hf;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        vin[1] = 1'b0;
        repeat (3) begin
          tick();
          #1 chk("rr idle ptr", {30'd0, ptr[1]}, 32'd3);
        end
      end
      vin[1] = 1'b1; din[1] = 8'(i);
      #1 chk("rr ptr", {30'd0, ptr[1]}, 32'(i % 4));
      tick();
      #1 chk("rr lane valid", {31'd0, vout1[i % 4]}, 32'd1);
      chk("rr lane data", {24'd0, dout1[(i % 4)*8 +: 8]}, 32'(i));
    end
    vin[1] = 1'b0;

    // Round robin stalls on a full lane 2 rather than skipping it
    rout[1] = 4'b1011;
    for (int j = 0; j < 4; j++) begin
      vin[1] = 1'b1; din[1] = 8'h70 + 8'(j);
      tick();
    end
    din[1] = 8'h74;
    #1 chk("rr block ready", {31'd0, rin[1]}, 32'd0);
    chk("rr block ptr", {30'd0, ptr[1]}, 32'd2);
    repeat (2) begin
      tick();
      #1 chk("rr hold ptr", {30'd0, ptr[1]}, 32'd2);
      chk("rr hold ready", {31'd0, rin[1]}, 32'd0);
    end
    rout[1] = 4'hf;
    #1 chk("rr unblock ready", {31'd0, rin[1]}, 32'd1);
    tick();
    vin[1] = 1'b0;
    #1 chk("rr after ptr", {30'd0, ptr[1]}, 32'd3);
    chk("rr after data", {24'd0, dout1[23:16]}, 32'h74);

    // Bad select and mid-run reset on the 3-lane instance
    rout[2] = 4'h0; vin[2] = 1'b1; din[2] = 8'h5A; sel[2] = 2'd3;
    #1 chk("badsel ready", {31'd0, rin[2]}, 32'd1);
    tick();
    din[2] = 8'h01; sel[2] = 2'd0;
    #1 chk("badsel vout", {29'd0, vout2}, 32'd0);
    chk("badsel err", {31'd0, err[2]}, 32'd1);
    tick();
    din[2] = 8'h02; sel[2] = 2'd1;
    tick();
    vin[2] = 1'b0;
    #1 chk("fill vout", {29'd0, vout2}, 32'h3);
    rst[2] = 1'b1;
    #1 chk("midreset ready", {31'd0, rin[2]}, 32'd0);
    tick();
    rst[2] = 1'b0;
    #1 chk("midreset vout", {29'd0, vout2}, 32'd0);
    chk("midreset err", {31'd0, err[2]}, 32'd0);
    chk("midreset data", {8'd0, dout2}, 32'd0);

    // Randomised traffic on all instances
    repeat (3000) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        rst[d]  = ($urandom_range(0, 199) == 0);
        vin[d]  = ($urandom_range(0, 3) != 0);
        din[d]  = 8'($urandom_range(0, 255));
        sel[d]  = 2'($urandom_range(0, 3));
        rout[d] = 4'($urandom_range(0, 15));
      end
    end
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0; vin[d] = 1'b0;
    end
    tick();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
